// File: rtl/soc_system_led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_system_led_pkg : default constants and step encoding for fader   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package soc_system_led_pkg;

  localparam int LED_N_DEF        = 8;
  localparam int LED_PWM_BITS_DEF = 8;
  localparam int LED_PRESCALE_DEF = 50;
  localparam int LED_FADE_DIV_DEF = 4;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

endpackage
`default_nettype wire

// File: rtl/soc_system_led_fade_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_system_led_fade_chan : one LED level register, ramp step, PWM cmp |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module soc_system_led_fade_chan
  import soc_system_led_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable_i,
  input  logic                fade_step_i,
  input  logic [PWM_BITS-1:0] target_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                busy_o
);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;
  step_e               dir;

  always_comb begin
    dir = STEP_HOLD;
    if (level_q < target_i) begin
      dir = STEP_UP;
    end else if (level_q > target_i) begin
      dir = STEP_DOWN;
    end
  end

  // Single-count steps toward the target can never overshoot or wrap.
  always_comb begin
    level_d = level_q;
    if (fade_step_i) begin
      case (dir)
        STEP_UP:   level_d = level_q + 1'b1;
        STEP_DOWN: level_d = level_q - 1'b1;
        default:   level_d = level_q;
      endcase
    end
  end

  always_comb begin
    led_d = enable_i && (level_q > pwm_cnt_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = (dir != STEP_HOLD);

endmodule
`default_nettype wire

// File: rtl/soc_system_led_fader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | soc_system_led_fader : PWM fader for the PIO LED port                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module soc_system_led_fader
  import soc_system_led_pkg::*;
#(
  parameter int N_LEDS   = LED_N_DEF,
  parameter int PWM_BITS = LED_PWM_BITS_DEF,
  parameter int PRESCALE = LED_PRESCALE_DEF,
  parameter int FADE_DIV = LED_FADE_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_LEDS-1:0]   led_in,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                enable,
  output logic [N_LEDS-1:0]   led_out,
  output logic                pwm_sync,
  output logic                busy
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FADE_W-1:0]   fade_q, fade_d;
  logic                pwm_sync_q, pwm_sync_d;
  logic                tick, wrap, fade_step;
  logic [N_LEDS-1:0]   chan_led;
  logic [N_LEDS-1:0]   chan_busy;

  assign tick      = enable && (presc_q == PRE_LAST);
  assign wrap      = tick && (pwm_cnt_q == '1);
  assign fade_step = wrap && (fade_q == FADE_LAST);

  // Disabling clears every counter so a re-enable starts a fresh period.
  always_comb begin
    presc_d    = presc_q;
    pwm_cnt_d  = pwm_cnt_q;
    fade_d     = fade_q;
    pwm_sync_d = 1'b0;
    if (!enable) begin
      presc_d   = '0;
      pwm_cnt_d = '0;
      fade_d    = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
      end
      if (wrap) begin
        fade_d = fade_step ? '0 : fade_q + 1'b1;
      end
      pwm_sync_d = wrap;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      fade_q     <= '0;
      pwm_sync_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_q     <= fade_d;
      pwm_sync_q <= pwm_sync_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    soc_system_led_fade_chan #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable_i   (enable),
      .fade_step_i(fade_step),
      .target_i   (led_in[i] ? brightness : '0),
      .pwm_cnt_i  (pwm_cnt_q),
      .led_o      (chan_led[i]),
      .busy_o     (chan_busy[i])
    );
  end

  assign led_out  = chan_led;
  assign pwm_sync = pwm_sync_q;
  // Gated by reset_n so busy drops asynchronously with the reset.
  assign busy     = reset_n & (|chan_busy);

endmodule
`default_nettype wire

// File: tb/tb_soc_system_led_fader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_soc_system_led_fader : scoreboard bench for the LED fader          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_soc_system_led_fader;

  localparam int N      = 8;
  localparam int PB     = 4;
  localparam int PS     = 2;
  localparam int FD     = 2;
  localparam int PERIOD = PS * (1 << PB);
  localparam int STEP   = PERIOD * FD;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  led_in;
  logic [PB-1:0] brightness;
  logic          enable;
  logic [N-1:0]  led_out;
  logic          pwm_sync;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  int t;
  int exp_q[$];

  soc_system_led_fader #(
    .N_LEDS  (N),
    .PWM_BITS(PB),
    .PRESCALE(PS),
    .FADE_DIV(FD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .led_in    (led_in),
    .brightness(brightness),
    .enable    (enable),
    .led_out   (led_out),
    .pwm_sync  (pwm_sync),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Cycles since counting (re)started; fade steps land where t is a multiple of STEP.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)     t <= 0;
    else if (!enable) t <= 0;
    else              t <= t + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_phase(input int ph);
    int g = 0;
    while ((t % STEP) != ph && g < 4 * STEP) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic busy_latency(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 3000);
    if (busy !== 1'b0) n = -1;
  endtask

  task automatic sync_gap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pwm_sync !== 1'b1 && n < 4 * PERIOD);
    if (pwm_sync !== 1'b1) n = -1;
  endtask

  task automatic measure_duty(output int on);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (pwm_sync !== 1'b1 && g < 4 * PERIOD);
    if (pwm_sync !== 1'b1) begin
      on = -1;
      return;
    end
    on = int'(led_out[0]);
    repeat (PERIOD - 1) begin
      @(negedge clk);
      on += int'(led_out[0]);
    end
  endtask

  task automatic test_reset;
    int got, exp;
    reset_n = 1'b0; enable = 1'b1; led_in = 8'hFF; brightness = 4'd15;
    repeat (3) @(negedge clk);
    n_checks++;
    if (led_out !== 8'h00) begin n_fail++; $display("FAIL reset_led_out: got %h expected 00", led_out); end
    n_checks++;
    if (pwm_sync !== 1'b0) begin n_fail++; $display("FAIL reset_pwm_sync: got %b expected 0", pwm_sync); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    led_in = 8'h00; brightness = 4'd0;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(PERIOD);
    exp_q.push_back(0);
    for (int k = 0; k < 3; k++) begin
      sync_gap(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL sync_gap_%0d: got %0d expected %0d", k, got, exp); end
    end
    measure_duty(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL idle_duty: got %0d expected %0d", got, exp); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_ramp_up;
    int got, exp;
    wait_phase(0);
    led_in = 8'h01; brightness = 4'd15;
    exp_q.push_back(15 * STEP);
    exp_q.push_back(30);
    exp_q.push_back(30);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy_rise: got %b expected 1", busy); end
    busy_latency(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL up_latency: got %0d expected %0d", got, exp); end
    for (int k = 0; k < 2; k++) begin
      measure_duty(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL up_duty_%0d: got %0d expected %0d", k, got, exp); end
    end
    n_checks++;
    if (led_out[N-1:1] !== '0) begin n_fail++; $display("FAIL up_other_leds: got %b expected 0", led_out[N-1:1]); end
  endtask

  task automatic test_brightness_down;
    int got, exp;
    wait_phase(0);
    brightness = 4'd4;
    exp_q.push_back(11 * STEP);
    exp_q.push_back(8);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL cap_busy_rise: got %b expected 1", busy); end
    busy_latency(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL cap_latency: got %0d expected %0d", got, exp); end
    measure_duty(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL cap_duty: got %0d expected %0d", got, exp); end
  endtask

  task automatic test_fade_out;
    int got, exp;
    wait_phase(0);
    brightness = 4'd7;
    exp_q.push_back(3 * STEP);
    exp_q.push_back(14);
    busy_latency(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL to7_latency: got %0d expected %0d", got, exp); end
    measure_duty(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL to7_duty: got %0d expected %0d", got, exp); end
    wait_phase(0);
    led_in = 8'h00;
    exp_q.push_back(7 * STEP);
    exp_q.push_back(0);
    busy_latency(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL off_latency: got %0d expected %0d", got, exp); end
    measure_duty(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL off_duty: got %0d expected %0d", got, exp); end
  endtask

  task automatic test_enable;
    int got, exp, syncs, highs;
    wait_phase(0);
    led_in = 8'h01; brightness = 4'd9;
    exp_q.push_back(9 * STEP);
    busy_latency(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL to9_latency: got %0d expected %0d", got, exp); end
    wait_phase(5);
    n_checks++;
    if (led_out[0] !== 1'b1) begin n_fail++; $display("FAIL en_led_before: got %b expected 1", led_out[0]); end
    enable = 1'b0;
    @(negedge clk);
    n_checks++;
    if (led_out !== 8'h00) begin n_fail++; $display("FAIL en_led_off: got %h expected 00", led_out); end
    syncs = 0; highs = 0;
    repeat (99) begin
      @(negedge clk);
      syncs += int'(pwm_sync);
      highs += int'(led_out != 8'h00) + int'(busy);
    end
    n_checks++;
    if (syncs !== 0) begin n_fail++; $display("FAIL en_sync_stopped: got %0d pulses expected 0", syncs); end
    n_checks++;
    if (highs !== 0) begin n_fail++; $display("FAIL en_outputs_idle: got %0d active samples expected 0", highs); end
    enable = 1'b1;
    exp_q.push_back(PERIOD);
    exp_q.push_back(18);
    sync_gap(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL en_first_sync: got %0d expected %0d", got, exp); end
    measure_duty(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL en_resume_duty: got %0d expected %0d", got, exp); end
  endtask

  task automatic test_reset_midramp;
    int got, exp;
    wait_phase(0);
    led_in = 8'h00;
    exp_q.push_back(9 * STEP);
    busy_latency(got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL to0_latency: got %0d expected %0d", got, exp); end
    wait_phase(0);
    led_in = 8'h01; brightness = 4'd15;
    repeat (5 * STEP + 5) @(negedge clk);
    n_checks++;
    if (led_out[0] !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_active: got led=%b busy=%b expected 1 1", led_out[0], busy);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (led_out !== 8'h00) begin n_fail++; $display("FAIL async_led_out: got %h expected 00", led_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
    n_checks++;
    if (pwm_sync !== 1'b0) begin n_fail++; $display("FAIL async_pwm_sync: got %b expected 0", pwm_sync); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(2);
    for (int k = 0; k < 2; k++) begin
      measure_duty(got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL restart_duty_%0d: got %0d expected %0d", k, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_brightness_down();
    test_fade_out();
    test_enable();
    test_reset_midramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_system_led_fader.md
Name: soc_system_led_fader

Overview:
- Downstream consumer of the 8-bit LED PIO output port; drives the physical LED pins.
- Converts each on/off LED bit into a PWM drive signal.
- Brightness ramps linearly toward a programmable cap when the bit is set, and toward zero when it is cleared.
- Runs entirely in the PIO's clock domain.

Parameters:
- N_LEDS, 8: number of LED channels.
- PWM_BITS, 8: width of the PWM counter, per-LED level and brightness cap.
- PRESCALE, 50: clk cycles per PWM count tick; legal range 1 to 65535.
- FADE_DIV, 4: PWM periods per fade step; minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- led_in  in  N_LEDS  on/off request per LED, from the PIO out_port
- brightness  in  PWM_BITS  maximum level applied to LEDs that are on
- enable  in  1  global run enable
- led_out  out  N_LEDS  registered PWM drive to the pins
- pwm_sync  out  1  one-cycle pulse at the start of each PWM period
- busy  out  1  high while any level differs from its target

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - reset_n is asynchronous and active-low, and is fixed as such.
  - While reset_n is low, all counters, levels, led_out, pwm_sync and busy are 0.
- Prescaler:
  - Counts 0 to PRESCALE-1, then wraps.
  - tick is asserted on the cycle the prescaler equals PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- PWM counter:
  - pwm_cnt, PWM_BITS wide, increments on tick and wraps from all-ones to 0.
  - pwm_sync is registered: high for exactly the one cycle in which pwm_cnt holds 0 after a wrap.
  - pwm_sync is not asserted after reset or on enable rise until the first wrap.
- Fade counter:
  - Counts 0 to FADE_DIV-1 and advances once per wrap.
  - fade_step is asserted on the wrap where the count is FADE_DIV-1.
- Target per LED: target[i] = led_in[i] ? brightness : 0. It is evaluated combinationally and used only at fade_step.
- Level update on fade_step, per channel:
  - level < target: level + 1.
  - level > target: level - 1.
  - Equal: hold.
  - Step size is exactly 1; the level never overshoots or wraps.
  - Levels change only at a period boundary, so no period is glitched.
- Output: led_out[i] is registered and equals enable AND (level[i] > pwm_cnt).
  - Duty is level / 2^PWM_BITS.
  - level 0 keeps the LED always off.
  - The maximum level gives (2^PWM_BITS - 1) counts on per period.
- busy is the OR over channels of (level != target), computed from registers plus the current inputs. It is not glitch-protected; consumers sample it synchronously.
- Enable low:
  - Prescaler, pwm_cnt and fade counter are held at 0 (synchronous clear).
  - Levels freeze.
  - led_out goes to 0 on the next edge; pwm_sync stays 0.
- Enable high again: counting restarts from 0 and levels resume from their frozen values.
- Simultaneous events:
  - A led_in or brightness change takes effect only at the next fade_step. Worst-case latency to the first level change is FADE_DIV*PRESCALE*2^PWM_BITS cycles.
  - If brightness changes while an LED is on, its level ramps toward the new cap in either direction.
- Reset mid-ramp: immediate return to the reset state.

Decomposition:
- Shared package/include soc_system_led_pkg holds the default constants: LED_N_DEF=8, LED_PWM_BITS_DEF=8, LED_PRESCALE_DEF=50, LED_FADE_DIV_DEF=4.
- Sub-module soc_system_led_fade_chan: one level register, the up/down/hold step logic and the output comparator. The top module instantiates it N_LEDS times.
- The top module holds the prescaler, PWM counter, fade counter, pwm_sync and busy reduction.

Test Plan:
All scenarios use PRESCALE=2, PWM_BITS=4, FADE_DIV=2, giving a 32-cycle period and a fade step every 64 cycles.
1. Release reset with enable=1 and led_in=0 -> led_out=0x00 and busy=0; the first pwm_sync pulse comes 32 cycles after release, then every 32 cycles.
2. led_in=0x01, brightness=15 -> busy goes high immediately; level[0] reaches 15 after 15 fade steps (960 cycles); busy then drops; led_out[0] is high 30 of every 32 cycles.
3. Hold led_in=0x01 at level 15, then set brightness=4 -> level falls by 1 per step to 4 after 11 steps; led_out[0] is high 8 of every 32 cycles.
4. Clear led_in at level 7 -> level goes 7 down to 0 in 7 steps; at level 0, led_out[0] stays low for a full period.
5. Drop enable at level 9 -> led_out=0 on the next edge and pwm_sync stops. Re-enable 100 cycles later -> duty resumes at 18/32 and the first pwm_sync pulse arrives 32 cycles after re-enable.
6. Assert reset_n low asynchronously mid-ramp at level 5 -> led_out, busy and pwm_sync go 0 without waiting for a clock edge; after release, ramping restarts from level 0.
